// File: rtl/inst_loader_pkg.sv
// Shared types and widths for the instruction-memory program loader.
package loader_pkg;

    localparam int unsigned COUNT_W = 16;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned WORD_W  = 32;

    typedef enum logic [2:0] {
        StIdle,
        StHdrHi,
        StHdrLo,
        StData,
        StCsum,
        StDone,
        StError
    } state_e;

    // States in which a frame is being received; the byte stream is open only here.
    function automatic logic is_loading(state_e s);
        return s inside {StHdrHi, StHdrLo, StData, StCsum};
    endfunction

    function automatic logic can_start(state_e s);
        return s inside {StIdle, StDone, StError};
    endfunction

endpackage

// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface inst_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    import loader_pkg::*;

    logic [BYTE_W-1:0] byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;

    modport master (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output mem_wen,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  mem_wen,
        input  mem_addr,
        input  mem_wdata
    );

endinterface

// File: rtl/inst_loader_word_assembler.sv
// Packs accepted data bytes MSB-first into 32-bit words and keeps the running XOR checksum.
module word_assembler
    import loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_ready,
    output logic              word_last,
    output logic [BYTE_W-1:0] csum
);

    logic [WORD_W-1:0] shift_q, shift_d;
    logic [1:0]        idx_q, idx_d;
    logic [BYTE_W-1:0] csum_q, csum_d;
    logic              ready_q;

    // High in the cycle the fourth byte of a word is being accepted.
    assign word_last = shift_en & (idx_q == 2'd3);

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        if (clear) begin
            shift_d = '0;
            idx_d   = '0;
            csum_d  = '0;
        end else if (shift_en) begin
            shift_d = {shift_q[WORD_W-BYTE_W-1:0], byte_in};
            idx_d   = idx_q + 2'd1;
            csum_d  = csum_q ^ byte_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            ready_q <= word_last & ~clear;
        end
    end

    assign word       = shift_q;
    assign word_ready = ready_q;
    assign csum       = csum_q;

endmodule

// File: rtl/inst_loader.sv
// Byte-serial program loader: writes a framed, checksummed stream into instruction memory
// and holds the CPU in reset until it lands intact. Optional idle timeout: LOADER_TIMEOUT_EN.
module inst_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    inst_loader_if.master      bus,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               cpu_hold,
    output logic [COUNT_W-1:0] words_loaded
);

    localparam logic [COUNT_W:0] MaxWords = (COUNT_W + 1)'(2 ** ADDR_W);

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] words_q, words_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    logic               byte_ready;
    logic               accept;
    logic               load;
    logic               data_en;
    logic               word_last;
    logic               word_ready;
    logic               oversize;
    logic               timeout;
    logic [WORD_W-1:0]  word;
    logic [BYTE_W-1:0]  csum;
    logic [COUNT_W-1:0] hdr_count;

    assign byte_ready = is_loading(state_q);
    assign accept     = bus.byte_valid & byte_ready;
    assign load       = start & can_start(state_q);
    assign data_en    = accept & (state_q == StData);
    assign hdr_count  = {count_q[COUNT_W-1:BYTE_W], bus.byte_in};
    assign oversize   = {1'b0, hdr_count} > MaxWords;

    word_assembler u_word_assembler (
        .clock      (clock),
        .reset      (reset),
        .clear      (load),
        .shift_en   (data_en),
        .byte_in    (bus.byte_in),
        .word       (word),
        .word_ready (word_ready),
        .word_last  (word_last),
        .csum       (csum)
    );

`ifdef LOADER_TIMEOUT_EN
    logic [31:0] timer_q, timer_d;

    always_comb begin
        timer_d = timer_q;
        if (load || accept) begin
            timer_d = '0;
        end else if (byte_ready) begin
            timer_d = timer_q + 32'd1;
        end
    end

    // Fires on the idle cycle that brings the count up to TIMEOUT_CYCLES.
    assign timeout = byte_ready && !accept && ((timer_q + 32'd1) >= TIMEOUT_CYCLES);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        words_d = words_q;
        addr_d  = addr_q;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d = StHdrHi;
                    words_d = '0;
                end
            end
            StHdrHi: begin
                if (accept) begin
                    count_d[COUNT_W-1:BYTE_W] = bus.byte_in;
                    state_d                   = StHdrLo;
                end
            end
            StHdrLo: begin
                if (accept) begin
                    count_d[BYTE_W-1:0] = bus.byte_in;
                    if (oversize) begin
                        state_d = StError;
                    end else if (hdr_count == '0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                // Address and count advance together with the registered write strobe.
                if (word_last) begin
                    addr_d  = ADDR_W'(BASE_ADDR + 32'(words_q));
                    words_d = words_q + 16'd1;
                    if (words_d == count_q) begin
                        state_d = StCsum;
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    state_d = (bus.byte_in == csum) ? StDone : StError;
                end
            end
            default: state_d = StIdle;
        endcase
        if (timeout) begin
            state_d = StError;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            count_q <= '0;
            words_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            words_q <= words_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.byte_ready = byte_ready;
    assign bus.mem_wen    = word_ready;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = word;

    assign busy         = byte_ready;
    assign done         = (state_q == StDone);
    assign error        = (state_q == StError);
    assign cpu_hold     = (state_q != StDone);
    assign words_loaded = words_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: vector table, hand sequences and random frames
// checked against a frame-parsing reference model.
module tb_inst_loader;
    import loader_pkg::*;

    localparam int AW_M   = 10;
    localparam int AW_S   = 4;
    localparam int BASE_S = 12;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        error;
        logic        hold;
        logic [15:0] words;
    } st_t;

    typedef struct {
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [7:0]  cs;
        bit          thr;
        bit          exp_done;
        bit          exp_err;
        int          exp_words;
    } vec_t;

    logic        clock   = 1'b0;
    logic        reset   = 1'b1;
    logic        start_m = 1'b0;
    logic        start_s = 1'b0;
    logic        busy_m, done_m, error_m, hold_m;
    logic        busy_s, done_s, error_s, hold_s;
    logic [15:0] wl_m, wl_s;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  frame[$];
    wr_t         exp_wr[$];
    wr_t         wr_m[$];
    wr_t         wr_s[$];
    vec_t        vt[7];

    inst_loader_if #(.ADDR_W(AW_M)) bus_m ();
    inst_loader_if #(.ADDR_W(AW_S)) bus_s ();

    inst_loader #(.ADDR_W(AW_M), .BASE_ADDR(0), .TIMEOUT_CYCLES(1000)) dut (
        .clock(clock), .reset(reset), .start(start_m), .bus(bus_m),
        .busy(busy_m), .done(done_m), .error(error_m), .cpu_hold(hold_m), .words_loaded(wl_m)
    );

    inst_loader #(.ADDR_W(AW_S), .BASE_ADDR(BASE_S), .TIMEOUT_CYCLES(8)) dut_s (
        .clock(clock), .reset(reset), .start(start_s), .bus(bus_s),
        .busy(busy_s), .done(done_s), .error(error_s), .cpu_hold(hold_s), .words_loaded(wl_s)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus_m.mem_wen === 1'b1) wr_m.push_back({16'(bus_m.mem_addr), bus_m.mem_wdata});
        if (bus_s.mem_wen === 1'b1) wr_s.push_back({16'(bus_s.mem_addr), bus_s.mem_wdata});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic st_t stat(input int sel);
        if (sel == 0) return '{busy: busy_m, done: done_m, error: error_m, hold: hold_m, words: wl_m};
        return '{busy: busy_s, done: done_s, error: error_s, hold: hold_s, words: wl_s};
    endfunction

    function automatic logic rdy(input int sel);
        return (sel == 0) ? bus_m.byte_ready : bus_s.byte_ready;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] b);
        if (sel == 0) begin
            bus_m.byte_valid = v;
            bus_m.byte_in    = b;
        end else begin
            bus_s.byte_valid = v;
            bus_s.byte_in    = b;
        end
    endtask

    // Returns just after the accepting rising edge; byte_valid stays high until the next call.
    task automatic send_byte(input int sel, input logic [7:0] b, input int gap);
        int n;
        for (int i = 0; i < gap; i++) begin
            @(negedge clock);
            drive(sel, 1'b0, 8'h00);
        end
        @(negedge clock);
        drive(sel, 1'b1, b);
        n = 0;
        while (!rdy(sel) && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (rdy(sel)) @(posedge clock);
        else check($sformatf("byte_ready wait sel%0d", sel), 64'(rdy(sel)), 64'd1);
    endtask

    task automatic end_stream(input int sel);
        @(negedge clock);
        drive(sel, 1'b0, 8'h00);
    endtask

    task automatic pulse_start(input int sel);
        @(negedge clock);
        if (sel == 0) start_m = 1'b1;
        else start_s = 1'b1;
        @(negedge clock);
        start_m = 1'b0;
        start_s = 1'b0;
    endtask

    // Reference: parse the frame as a whole and list the writes it should produce.
    task automatic model(input int aw, input int base, output bit m_done, output bit m_err,
                         output int m_words, output int m_bytes);
        int          n;
        logic [7:0]  x;
        logic [31:0] w;
        exp_wr.delete();
        n = int'({frame[0], frame[1]});
        if (n > (1 << aw)) begin
            m_done  = 1'b0;
            m_err   = 1'b1;
            m_words = 0;
            m_bytes = 2;
            return;
        end
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            w = {frame[2+4*i], frame[3+4*i], frame[4+4*i], frame[5+4*i]};
            x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
            exp_wr.push_back({16'((base + i) % (1 << aw)), w});
        end
        m_done  = (frame[2+4*n] == x);
        m_err   = !m_done;
        m_words = n;
        m_bytes = 3 + 4 * n;
    endtask

    task automatic build_words(input int n, input logic [31:0] w[3], input logic [7:0] cs);
        frame.delete();
        frame.push_back(8'(n >> 8));
        frame.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            frame.push_back(w[i][31:24]);
            frame.push_back(w[i][23:16]);
            frame.push_back(w[i][15:8]);
            frame.push_back(w[i][7:0]);
        end
        frame.push_back(cs);
    endtask

    task automatic run_frame(input int sel, input bit thr, input bit exp_done, input bit exp_err,
                             input int exp_words, input string tag);
        bit  md, me;
        int  mw, mb;
        wr_t got[$];
        if (sel == 0) model(AW_M, 0, md, me, mw, mb);
        else model(AW_S, BASE_S, md, me, mw, mb);
        if (sel == 0) wr_m.delete();
        else wr_s.delete();
        pulse_start(sel);
        check({tag, " after start"}, 64'(stat(sel)),
              64'(st_t'{busy: 1'b1, done: 1'b0, error: 1'b0, hold: 1'b1, words: 16'd0}));
        for (int i = 0; i < mb; i++) send_byte(sel, frame[i], thr ? int'($urandom_range(0, 3)) : 0);
        end_stream(sel);
        repeat (2) @(negedge clock);
        check({tag, " status"}, 64'(stat(sel)),
              64'(st_t'{busy: 1'b0, done: exp_done, error: exp_err, hold: !exp_done,
                        words: 16'(exp_words)}));
        if (sel == 0) got = wr_m;
        else got = wr_s;
        check({tag, " write count"}, 64'(got.size()), 64'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < got.size(); i++)
            check($sformatf("%s write%0d", tag, i), 64'(got[i]), 64'(exp_wr[i]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t reached without finishing, required finish earlier", $time);
        $fatal(1);
    end

    initial begin
        logic [31:0] w3[3];
        bit          md, me;
        int          mw, mb;

        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        vt[0] = '{2, 32'h24080005, 32'h00000020, 32'h0, 8'h09, 1'b0, 1'b1, 1'b0, 2};
        vt[1] = '{2, 32'h24080005, 32'h00000020, 32'h0, 8'h00, 1'b0, 1'b0, 1'b1, 2};
        vt[2] = '{0, 32'h0, 32'h0, 32'h0, 8'h00, 1'b0, 1'b1, 1'b0, 0};
        vt[3] = '{2, 32'h24080005, 32'h00000020, 32'h0, 8'h09, 1'b1, 1'b1, 1'b0, 2};
        vt[4] = '{3, 32'hdeadbeef, 32'h01234567, 32'hffffffff, 8'h22, 1'b1, 1'b1, 1'b0, 3};
        vt[5] = '{1, 32'h11223344, 32'h0, 32'h0, 8'h45, 1'b0, 1'b0, 1'b1, 1};
        vt[6] = '{0, 32'h0, 32'h0, 32'h0, 8'h5a, 1'b0, 1'b0, 1'b1, 0};

        // Reset, then idle with no start.
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        check("in reset status", 64'(stat(0)),
              64'(st_t'{busy: 1'b0, done: 1'b0, error: 1'b0, hold: 1'b1, words: 16'd0}));
        check("in reset addr/data", {16'(bus_m.mem_addr), bus_m.mem_wdata}, 64'd0);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        check("idle status", 64'(stat(0)),
              64'(st_t'{busy: 1'b0, done: 1'b0, error: 1'b0, hold: 1'b1, words: 16'd0}));
        check("idle byte_ready", 64'(bus_m.byte_ready), 64'd0);
        check("idle small byte_ready", 64'(bus_s.byte_ready), 64'd0);
        check("idle no writes", 64'(wr_m.size() + wr_s.size()), 64'd0);

        foreach (vt[k]) begin
            w3 = '{vt[k].w0, vt[k].w1, vt[k].w2};
            build_words(vt[k].n, w3, vt[k].cs);
            run_frame(0, vt[k].thr, vt[k].exp_done, vt[k].exp_err, vt[k].exp_words,
                      $sformatf("vec%0d", k));
        end

        // Start while busy must be ignored.
        wr_m.delete();
        pulse_start(0);
        send_byte(0, 8'h00, 0);
        send_byte(0, 8'h01, 0);
        end_stream(0);
        pulse_start(0);
        check("start while busy", 64'(stat(0)),
              64'(st_t'{busy: 1'b1, done: 1'b0, error: 1'b0, hold: 1'b1, words: 16'd0}));
        send_byte(0, 8'h11, 0);
        send_byte(0, 8'h22, 0);
        send_byte(0, 8'h33, 0);
        send_byte(0, 8'h44, 1);
        send_byte(0, 8'h44, 0);
        end_stream(0);
        repeat (2) @(negedge clock);
        check("busy-start final", 64'(stat(0)),
              64'(st_t'{busy: 1'b0, done: 1'b1, error: 1'b0, hold: 1'b0, words: 16'd1}));
        check("busy-start writes", 64'(wr_m.size()), 64'd1);
        if (wr_m.size() > 0) check("busy-start write0", 64'(wr_m[0]), {16'd0, 32'h0, 32'h11223344});

        // Small instance: oversize count, then a full-depth load that wraps the address.
        frame = '{8'h00, 8'h11};
        run_frame(1, 1'b0, 1'b0, 1'b1, 0, "over17");
        frame.delete();
        frame.push_back(8'h00);
        frame.push_back(8'h10);
        begin
            logic [7:0] x;
            x = 8'h00;
            for (int i = 0; i < 64; i++) begin
                frame.push_back(8'($urandom()));
                x ^= frame[frame.size()-1];
            end
            frame.push_back(x);
        end
        run_frame(1, 1'b0, 1'b1, 1'b0, 16, "full16");

        // Stall after the header.
        pulse_start(1);
        send_byte(1, 8'h00, 0);
        send_byte(1, 8'h02, 0);
        end_stream(1);
`ifdef LOADER_TIMEOUT_EN
        repeat (7) @(posedge clock);
        #1 check("timeout not yet", 64'(stat(1)),
                 64'(st_t'{busy: 1'b1, done: 1'b0, error: 1'b0, hold: 1'b1, words: 16'd0}));
        @(posedge clock);
        #1 check("timeout error", 64'(stat(1)),
                 64'(st_t'{busy: 1'b0, done: 1'b0, error: 1'b1, hold: 1'b1, words: 16'd0}));
`else
        repeat (20) @(negedge clock);
        check("no timeout stays busy", 64'(stat(1)),
              64'(st_t'{busy: 1'b1, done: 1'b0, error: 1'b0, hold: 1'b1, words: 16'd0}));
`endif

        // Reset in the middle of the first word.
        wr_m.delete();
        pulse_start(0);
        send_byte(0, 8'h00, 0);
        send_byte(0, 8'h02, 0);
        send_byte(0, 8'h24, 0);
        send_byte(0, 8'h08, 0);
        @(negedge clock);
        reset = 1'b0;
        drive(0, 1'b0, 8'h00);
        #1 check("mid-load reset status", 64'(stat(0)),
                 64'(st_t'{busy: 1'b0, done: 1'b0, error: 1'b0, hold: 1'b1, words: 16'd0}));
        check("mid-load reset byte_ready", 64'(bus_m.byte_ready), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        check("mid-load reset no write", 64'(wr_m.size()), 64'd0);
        check("mid-load reset idle", 64'(stat(0)),
              64'(st_t'{busy: 1'b0, done: 1'b0, error: 1'b0, hold: 1'b1, words: 16'd0}));
        w3 = '{vt[0].w0, vt[0].w1, vt[0].w2};
        build_words(2, w3, 8'h09);
        run_frame(0, 1'b1, 1'b1, 1'b0, 2, "restart");

        // Random frames against the reference model.
        for (int r = 0; r < 24; r++) begin
            int         n;
            logic [7:0] x;
            frame.delete();
            if ($urandom_range(0, 7) == 0) n = 1025 + int'($urandom_range(0, 200));
            else n = int'($urandom_range(0, 5));
            frame.push_back(8'(n >> 8));
            frame.push_back(8'(n));
            if (n <= 1024) begin
                x = 8'h00;
                for (int i = 0; i < 4 * n; i++) begin
                    frame.push_back(8'($urandom()));
                    x ^= frame[frame.size()-1];
                end
                if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
                frame.push_back(x);
            end
            model(AW_M, 0, md, me, mw, mb);
            run_frame(0, 1'(r % 2), md, me, mw, $sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
